mul_shared_arbiter: RTL and testbench

Shares one external signed multiplier between two requesters, for example a leaky_relu_cell and a neighbouring scale/bias cell in the post-processing stage of axi_generic_conv. The external multiplier is a signed_mul with its input register enabled, its multiply stage enabled and its output register disabled. Each requester submits operand pairs with a valid/ready handshake and receives its products, in order, on its own result channel. A per-channel credit counter sizes the result buffering so that no in-flight product is ever dropped.

---
 rtl/mul_shared_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mul_shared_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_shared_arbiter.sv
// rtl/mul_shared_arbiter.sv - two-channel arbiter sharing one pipelined signed multiplier
// Optional build macro MUL_ARB_FIXED_PRIO_EN: channel 0 always wins instead of round-robin.
module mul_shared_arbiter #(
   parameter int OP_WIDTH       = 32,
   parameter int RES_WIDTH      = 64,
   parameter int TAG_WIDTH      = 2,
   parameter int RES_FIFO_DEPTH = 4,
   parameter int SIM_DELAY      = 1
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 aclken,
   input  logic [OP_WIDTH-1:0]  req0_op_a,
   input  logic [OP_WIDTH-1:0]  req0_op_b,
   input  logic [TAG_WIDTH-1:0] req0_tag,
   input  logic                 req0_vld,
   output logic                 req0_rdy,
   input  logic [OP_WIDTH-1:0]  req1_op_a,
   input  logic [OP_WIDTH-1:0]  req1_op_b,
   input  logic [TAG_WIDTH-1:0] req1_tag,
   input  logic                 req1_vld,
   output logic                 req1_rdy,
   output logic [RES_WIDTH-1:0] res0_data,
   output logic [TAG_WIDTH-1:0] res0_tag,
   output logic                 res0_vld,
   input  logic                 res0_rdy,
   output logic [RES_WIDTH-1:0] res1_data,
   output logic [TAG_WIDTH-1:0] res1_tag,
   output logic                 res1_vld,
   input  logic                 res1_rdy,
   output logic [OP_WIDTH-1:0]  mul_op_a,
   output logic [OP_WIDTH-1:0]  mul_op_b,
   output logic [1:0]           mul_ce,
   input  logic [RES_WIDTH-1:0] mul_res
);

   localparam int CW = $clog2(RES_FIFO_DEPTH + 1);
   localparam int PW = (RES_FIFO_DEPTH > 1) ? $clog2(RES_FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(RES_FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(RES_FIFO_DEPTH - 1);

   generate
      if (RES_FIFO_DEPTH < 2 || RES_WIDTH != 2 * OP_WIDTH || SIM_DELAY < 0) begin : g_param_check
         $error("mul_shared_arbiter: illegal parameter combination");
      end
   endgenerate

   logic [OP_WIDTH-1:0]  w_op_a     [2];
   logic [OP_WIDTH-1:0]  w_op_b     [2];
   logic [TAG_WIDTH-1:0] w_tag_in   [2];
   logic [RES_WIDTH-1:0] w_res_data [2];
   logic [TAG_WIDTH-1:0] w_res_tag  [2];
   logic [1:0]           w_req_vld;
   logic [1:0]           w_res_rdy;
   logic [1:0]           w_elig;
   logic [1:0]           w_accept;
   logic [1:0]           w_res_vld;
   logic                 w_grant_vld;
   logic                 w_grant_id;

   logic                 r_s1_vld;
   logic                 r_s1_id;
   logic [TAG_WIDTH-1:0] r_s1_tag;
   logic                 r_s2_vld;
   logic                 r_s2_id;
   logic [TAG_WIDTH-1:0] r_s2_tag;

   assign w_op_a[0]   = req0_op_a;
   assign w_op_a[1]   = req1_op_a;
   assign w_op_b[0]   = req0_op_b;
   assign w_op_b[1]   = req1_op_b;
   assign w_tag_in[0] = req0_tag;
   assign w_tag_in[1] = req1_tag;
   assign w_req_vld   = {req1_vld, req0_vld};
   assign w_res_rdy   = {res1_rdy, res0_rdy};

   // Reset gates the grant so no request is acknowledged while aresetn is low.
   assign w_grant_vld = aresetn & aclken & (|w_elig);
   assign w_accept[0] = w_grant_vld & ~w_grant_id;
   assign w_accept[1] = w_grant_vld & w_grant_id;

`ifdef MUL_ARB_FIXED_PRIO_EN
   assign w_grant_id = ~w_elig[0];
`else
   logic r_rr_ptr;

   assign w_grant_id = (w_elig == 2'b11) ? r_rr_ptr : w_elig[1];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rr_ptr <= 1'b0;
      end else if (w_grant_vld) begin
         r_rr_ptr <= ~w_grant_id;
      end
   end
`endif

   assign mul_op_a = w_grant_vld ? w_op_a[w_grant_id] : '0;
   assign mul_op_b = w_grant_vld ? w_op_b[w_grant_id] : '0;
   assign mul_ce   = {r_s1_vld & aclken, w_grant_vld};

   // S1 tracks the multiplier input register, S2 its multiply-stage register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_s1_vld <= 1'b0;
         r_s1_id  <= 1'b0;
         r_s1_tag <= '0;
         r_s2_vld <= 1'b0;
         r_s2_id  <= 1'b0;
         r_s2_tag <= '0;
      end else if (aclken) begin
         r_s1_vld <= w_grant_vld;
         r_s1_id  <= w_grant_id;
         r_s1_tag <= w_tag_in[w_grant_id];
         r_s2_vld <= r_s1_vld;
         r_s2_id  <= r_s1_id;
         r_s2_tag <= r_s1_tag;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_ch
      logic [PW-1:0]        r_wr_ptr;
      logic [PW-1:0]        r_rd_ptr;
      logic [CW-1:0]        r_count;
      logic [CW-1:0]        r_credit;
      logic [RES_WIDTH-1:0] r_data [RES_FIFO_DEPTH];
      logic [TAG_WIDTH-1:0] r_tag  [RES_FIFO_DEPTH];
      logic                 w_wr;
      logic                 w_pop;

      assign w_elig[g]     = w_req_vld[g] & (r_credit < DEPTH_C);
      assign w_wr          = aclken & r_s2_vld & (r_s2_id == 1'(g));
      assign w_pop         = aclken & w_res_vld[g] & w_res_rdy[g];
      assign w_res_vld[g]  = (r_count != '0);
      assign w_res_data[g] = w_res_vld[g] ? r_data[r_rd_ptr] : '0;
      assign w_res_tag[g]  = w_res_vld[g] ? r_tag[r_rd_ptr] : '0;

      // Credit covers S1, S2 and the FIFO, so a granted op always has a free slot.
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_credit <= '0;
         end else begin
            if (w_wr) begin
               r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
            case ({w_accept[g], w_pop})
               2'b10:   r_credit <= r_credit + 1'b1;
               2'b01:   r_credit <= r_credit - 1'b1;
               default: r_credit <= r_credit;
            endcase
         end
      end

      always_ff @(posedge aclk) begin
         if (w_wr) begin
            r_data[r_wr_ptr] <= mul_res;
            r_tag[r_wr_ptr]  <= r_s2_tag;
         end
      end
   end

   assign req0_rdy  = w_accept[0];
   assign req1_rdy  = w_accept[1];
   assign res0_vld  = w_res_vld[0];
   assign res1_vld  = w_res_vld[1];
   assign res0_data = w_res_data[0];
   assign res1_data = w_res_data[1];
   assign res0_tag  = w_res_tag[0];
   assign res1_tag  = w_res_tag[1];

endmodule

// File: tb/tb_mul_shared_arbiter.sv
// tb/tb_mul_shared_arbiter.sv - directed self-checking bench for mul_shared_arbiter
module tb_mul_shared_arbiter;

   localparam int OW = 32;
   localparam int RW = 64;
   localparam int TW = 2;

   logic                 aclk = 1'b0;
   logic                 aresetn;
   logic                 aclken;
   logic [OW-1:0]        req0_op_a, req0_op_b, req1_op_a, req1_op_b;
   logic [TW-1:0]        req0_tag, req1_tag;
   logic                 req0_vld, req1_vld, req0_rdy, req1_rdy;
   logic [RW-1:0]        res0_data, res1_data;
   logic [TW-1:0]        res0_tag, res1_tag;
   logic                 res0_vld, res1_vld, res0_rdy, res1_rdy;
   logic [OW-1:0]        mul_op_a, mul_op_b;
   logic [1:0]           mul_ce;
   logic signed [RW-1:0] mul_res;

   logic signed [OW-1:0] r_mul_a, r_mul_b;

   int n_vec = 0;
   int n_err = 0;
   int i0, i1;
   logic g0;
   logic [65:0] q0[$];
   logic [65:0] q1[$];

   logic signed [OW-1:0] t0a [6] = '{5, -4, 100, 7, -1, 12};
   logic signed [OW-1:0] t0b [6] = '{6, 9, -3, 7, -1, 0};
   logic signed [RW-1:0] t0p [6] = '{30, -36, -300, 49, 1, 0};
   logic signed [OW-1:0] t1a [6] = '{11, -13, 2, 3, 4, 5};
   logic signed [OW-1:0] t1b [6] = '{2, -2, 1000, 3, 4, 5};
   logic signed [RW-1:0] t1p [6] = '{22, 26, 2000, 9, 16, 25};

   logic [10:0] en_vec  = 11'b11110001111;
   logic [10:0] rdy_vec = 11'b00000001111;
   logic [10:0] vld_vec = 11'b01111111000;
   logic [1:0]  ce_exp [11] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00,
                                2'b10, 2'b00, 2'b00, 2'b00};

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (mul_ce[0]) begin
         r_mul_a <= mul_op_a;
         r_mul_b <= mul_op_b;
      end
      if (mul_ce[1]) begin
         mul_res <= RW'(r_mul_a) * RW'(r_mul_b);
      end
   end

   mul_shared_arbiter dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .aclken    (aclken),
      .req0_op_a (req0_op_a),
      .req0_op_b (req0_op_b),
      .req0_tag  (req0_tag),
      .req0_vld  (req0_vld),
      .req0_rdy  (req0_rdy),
      .req1_op_a (req1_op_a),
      .req1_op_b (req1_op_b),
      .req1_tag  (req1_tag),
      .req1_vld  (req1_vld),
      .req1_rdy  (req1_rdy),
      .res0_data (res0_data),
      .res0_tag  (res0_tag),
      .res0_vld  (res0_vld),
      .res0_rdy  (res0_rdy),
      .res1_data (res1_data),
      .res1_tag  (res1_tag),
      .res1_vld  (res1_vld),
      .res1_rdy  (res1_rdy),
      .mul_op_a  (mul_op_a),
      .mul_op_b  (mul_op_b),
      .mul_ce    (mul_ce),
      .mul_res   (mul_res)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", name, obs, exp);
      end
   endtask

   task automatic set0(input int i, input logic v);
      req0_op_a = t0a[i];
      req0_op_b = t0b[i];
      req0_tag  = 2'(i);
      req0_vld  = v;
   endtask

   task automatic set1(input int i, input logic v);
      req1_op_a = t1a[i];
      req1_op_b = t1b[i];
      req1_tag  = 2'(3 - i);
      req1_vld  = v;
   endtask

   task automatic exp0(input int i);
      q0.push_back({2'(i), t0p[i]});
   endtask

   task automatic exp1(input int i);
      q1.push_back({2'(3 - i), t1p[i]});
   endtask

   task automatic collect();
      if (res0_vld) begin
         if (q0.size() == 0) begin
            chk("res0_stale", 64'(res0_vld), 64'd0);
         end else begin
            chk("res0_data", res0_data, q0[0][63:0]);
            chk("res0_tag", 64'(res0_tag), 64'(q0[0][65:64]));
            if (res0_rdy && aclken) void'(q0.pop_front());
         end
      end
      if (res1_vld) begin
         if (q1.size() == 0) begin
            chk("res1_stale", 64'(res1_vld), 64'd0);
         end else begin
            chk("res1_data", res1_data, q1[0][63:0]);
            chk("res1_tag", 64'(res1_tag), 64'(q1[0][65:64]));
            if (res1_rdy && aclken) void'(q1.pop_front());
         end
      end
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge aclk);
         #1;
         collect();
      end
   endtask

   task automatic rst_pulse();
      @(negedge aclk);
      set0(0, 1'b0);
      set1(0, 1'b0);
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      q0.delete();
      q1.delete();
   endtask

   task automatic chk_empty(input string name);
      chk({name, "_q0"}, 64'(q0.size()), 64'd0);
      chk({name, "_q1"}, 64'(q1.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      aresetn  = 1'b0;
      aclken   = 1'b1;
      res0_rdy = 1'b1;
      res1_rdy = 1'b1;
      set0(0, 1'b1);
      set1(0, 1'b1);
      repeat (2) @(negedge aclk);
      #1;
      chk("rst_rdy0", 64'(req0_rdy), 64'd0);
      chk("rst_rdy1", 64'(req1_rdy), 64'd0);
      chk("rst_ce", 64'(mul_ce), 64'd0);
      chk("rst_op_a", 64'(mul_op_a), 64'd0);
      chk("rst_op_b", 64'(mul_op_b), 64'd0);
      chk("rst_vld0", 64'(res0_vld), 64'd0);
      chk("rst_data0", res0_data, 64'd0);
      chk("rst_vld1", 64'(res1_vld), 64'd0);
      @(negedge aclk);
      set0(0, 1'b0);
      set1(0, 1'b0);
      aresetn = 1'b1;

      // single op: 3 * -7, tag 1
      @(negedge aclk);
      req0_op_a = 32'd3;
      req0_op_b = 32'hFFFFFFF9;
      req0_tag  = 2'd1;
      req0_vld  = 1'b1;
      #1;
      chk("t2_rdy0", 64'(req0_rdy), 64'd1);
      chk("t2_ce_c0", 64'(mul_ce), 64'd1);
      chk("t2_op_a", 64'(mul_op_a), 64'd3);
      chk("t2_op_b", 64'(mul_op_b), 64'h00000000FFFFFFF9);
      q0.push_back({2'd1, 64'hFFFFFFFFFFFFFFEB});
      @(negedge aclk);
      req0_vld = 1'b0;
      #1;
      chk("t2_ce_c1", 64'(mul_ce), 64'd2);
      chk("t2_vld_c1", 64'(res0_vld), 64'd0);
      @(negedge aclk);
      #1;
      chk("t2_ce_c2", 64'(mul_ce), 64'd0);
      chk("t2_vld_c2", 64'(res0_vld), 64'd0);
      @(negedge aclk);
      #1;
      chk("t2_vld_c3", 64'(res0_vld), 64'd1);
      collect();
      @(negedge aclk);
      #1;
      chk("t2_vld_c4", 64'(res0_vld), 64'd0);
      chk_empty("t2");

      // both channels streaming, all consumers ready
      rst_pulse();
      i0 = 0;
      i1 = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge aclk);
         set0(i0, 1'b1);
         set1(i1, 1'b1);
         #1;
`ifdef MUL_ARB_FIXED_PRIO_EN
         g0 = 1'b1;
`else
         g0 = (k % 2 == 0);
`endif
         chk("t3_rdy0", 64'(req0_rdy), 64'(g0));
         chk("t3_rdy1", 64'(req1_rdy), 64'(!g0));
         if (g0) begin
            exp0(i0);
            i0++;
         end else begin
            exp1(i1);
            i1++;
         end
         collect();
      end
      @(negedge aclk);
      set0(0, 1'b0);
      set1(0, 1'b0);
      #1;
      collect();
      drain(8);
      chk_empty("t3");

      // ch1 consumer stalled: exactly 4 credits, then ch0 owns the multiplier
      rst_pulse();
      i0 = 0;
      i1 = 0;
      res1_rdy = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge aclk);
         set1(i1, 1'b1);
         #1;
         chk("t4_rdy1_fill", 64'(req1_rdy), 64'(k < 4));
         if (k < 4) begin
            exp1(i1);
            i1++;
         end
         collect();
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         set0(i0, 1'b1);
         set1(i1, 1'b1);
         #1;
         chk("t4_rdy0", 64'(req0_rdy), 64'd1);
         chk("t4_rdy1", 64'(req1_rdy), 64'd0);
         chk("t4_res1_held", 64'(res1_vld), 64'd1);
         exp0(i0);
         i0++;
         collect();
      end
      @(negedge aclk);
      set0(0, 1'b0);
      set1(0, 1'b0);
      res1_rdy = 1'b1;
      #1;
      collect();
      drain(10);
      chk_empty("t4");

      // operand extremes
      @(negedge aclk);
      req0_op_a = 32'h80000000;
      req0_op_b = 32'h80000000;
      req0_tag  = 2'd2;
      req0_vld  = 1'b1;
      #1;
      chk("t5_rdy0", 64'(req0_rdy), 64'd1);
      q0.push_back({2'd2, 64'h4000000000000000});
      collect();
      @(negedge aclk);
      req0_vld  = 1'b0;
      req1_op_a = 32'h7FFFFFFF;
      req1_op_b = 32'hFFFFFFFF;
      req1_tag  = 2'd3;
      req1_vld  = 1'b1;
      #1;
      chk("t5_rdy1", 64'(req1_rdy), 64'd1);
      q1.push_back({2'd3, 64'hFFFFFFFF80000001});
      collect();
      @(negedge aclk);
      set1(0, 1'b0);
      #1;
      collect();
      drain(6);
      chk_empty("t5");

      // aclken low for 3 cycles with a result waiting and ops in flight
      rst_pulse();
      for (int k = 0; k < 11; k++) begin
         @(negedge aclk);
         aclken = en_vec[k];
         if (k < 7) set0((k < 4) ? k : 4, 1'b1);
         else set0(0, 1'b0);
         #1;
         chk("t6_rdy0", 64'(req0_rdy), 64'(rdy_vec[k]));
         chk("t6_ce", 64'(mul_ce), 64'(ce_exp[k]));
         chk("t6_vld0", 64'(res0_vld), 64'(vld_vec[k]));
         if (rdy_vec[k]) exp0(k);
         collect();
      end
      chk_empty("t6");

      // reset with 2 results buffered and 2 ops in the multiplier
      rst_pulse();
      res0_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         set0(k, 1'b1);
         #1;
         chk("t7_rdy0", 64'(req0_rdy), 64'(k < 4));
         if (k < 4) exp0(k);
         collect();
      end
      set1(0, 1'b1);
      aresetn = 1'b0;
      #1;
      chk("t7_rst_rdy0", 64'(req0_rdy), 64'd0);
      chk("t7_rst_rdy1", 64'(req1_rdy), 64'd0);
      chk("t7_rst_vld0", 64'(res0_vld), 64'd0);
      chk("t7_rst_data0", res0_data, 64'd0);
      chk("t7_rst_tag0", 64'(res0_tag), 64'd0);
      chk("t7_rst_ce", 64'(mul_ce), 64'd0);
      chk("t7_rst_op_a", 64'(mul_op_a), 64'd0);
      q0.delete();
      @(negedge aclk);
      aresetn  = 1'b1;
      res0_rdy = 1'b1;
      set0(0, 1'b0);
      set1(0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         #1;
         chk("t7_no_stale0", 64'(res0_vld), 64'd0);
         chk("t7_no_stale1", 64'(res1_vld), 64'd0);
      end
      @(negedge aclk);
      set0(1, 1'b1);
      set1(1, 1'b1);
      #1;
      chk("t7_first_rdy0", 64'(req0_rdy), 64'd1);
      chk("t7_first_rdy1", 64'(req1_rdy), 64'd0);
      exp0(1);
      collect();
      @(negedge aclk);
      set0(0, 1'b0);
      set1(0, 1'b0);
      #1;
      collect();
      drain(6);
      chk_empty("t7");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
